// File: rtl/c1_dtack_sched_if.sv
// 68K bus-cycle signals shared by the C1 zone decoder, the DTACK scheduler and the memory backend.
// The master modport is the scheduler side; slave is the bus/backend side driving it.
interface c1_dtack_sched_if;
    logic       nAS;
    logic       RW;
    logic       nROM_ZONE;
    logic       nSROM_ZONE;
    logic       nWRAM_ZONE;
    logic       nPORT_ZONE;
    logic       nCARD_ZONE;
    logic       nROMWAIT;
    logic       nPWAIT0;
    logic       nPWAIT1;
    logic       MEM_REQ;
    logic       MEM_WR;
    logic [2:0] MEM_ZONE;
    logic       MEM_ACK;
    logic       nDTACK;
    logic       nBERR;
    logic       BUSY;

    modport master (
        input  nAS, RW, nROM_ZONE, nSROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nCARD_ZONE,
        input  nROMWAIT, nPWAIT0, nPWAIT1, MEM_ACK,
        output MEM_REQ, MEM_WR, MEM_ZONE, nDTACK, nBERR, BUSY
    );

    modport slave (
        output nAS, RW, nROM_ZONE, nSROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nCARD_ZONE,
        output nROMWAIT, nPWAIT0, nPWAIT1, MEM_ACK,
        input  MEM_REQ, MEM_WR, MEM_ZONE, nDTACK, nBERR, BUSY
    );
endinterface

// File: rtl/c1_dtack_sched.sv
// Per-bus-cycle 68K sequencer: one backend request per nAS assertion, nDTACK once both the zone
// wait states have elapsed and the backend has acked, nBERR on backend timeout.
module c1_dtack_sched #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 10
) (
    input logic                CLK_68KCLK,
    input logic                RESET,
    c1_dtack_sched_if.master   bus
);

    typedef enum logic [2:0] {StIdle, StWait, StDone, StBerr, StDrain} state_e;

    state_e        state_q;
    logic [1:0]    wait_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          ack_seen_q;

    logic [2:0]    zone_code;
    logic [1:0]    wait_w;
    logic          acked;

    assign acked = ack_seen_q | bus.MEM_ACK;

    always_comb begin
        zone_code = 3'd0;
        wait_w    = 2'd0;
        if (!bus.nROM_ZONE) begin
            zone_code = 3'd1;
            wait_w    = bus.nROMWAIT ? 2'd0 : 2'd2;
        end else if (!bus.nSROM_ZONE) begin
            zone_code = 3'd2;
        end else if (!bus.nWRAM_ZONE) begin
            zone_code = 3'd3;
        end else if (!bus.nPORT_ZONE) begin
            zone_code = 3'd4;
            case ({bus.nPWAIT1, bus.nPWAIT0})
                2'b10:   wait_w = 2'd2;
                2'b01:   wait_w = 2'd3;
                default: wait_w = 2'd0;
            endcase
        end else if (!bus.nCARD_ZONE) begin
            zone_code = 3'd5;
            wait_w    = 2'd2;
        end
    end

    always_ff @(posedge CLK_68KCLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            to_cnt_q     <= '0;
            ack_seen_q   <= 1'b0;
            bus.MEM_REQ  <= 1'b0;
            bus.MEM_WR   <= 1'b0;
            bus.MEM_ZONE <= 3'd0;
            bus.nDTACK   <= 1'b1;
            bus.nBERR    <= 1'b1;
            bus.BUSY     <= 1'b0;
        end else begin
            bus.MEM_REQ <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!bus.nAS && zone_code != 3'd0) begin
                        bus.MEM_ZONE <= zone_code;
                        bus.MEM_WR   <= ~bus.RW;
                        bus.MEM_REQ  <= 1'b1;
                        bus.BUSY     <= 1'b1;
                        wait_cnt_q   <= wait_w;
                        to_cnt_q     <= '0;
                        ack_seen_q   <= 1'b0;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt_q != 2'd0) wait_cnt_q <= wait_cnt_q - 2'd1;
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (bus.MEM_ACK) ack_seen_q <= 1'b1;
                    // An aborted cycle must never see DTACK, so nAS release is checked first.
                    if (bus.nAS) begin
                        bus.BUSY <= ~acked;
                        state_q  <= acked ? StIdle : StDrain;
                    end else if (wait_cnt_q == 2'd0 && acked) begin
                        bus.nDTACK <= 1'b0;
                        state_q    <= StDone;
                    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        bus.nBERR <= 1'b0;
                        state_q   <= StBerr;
                    end
                end
                StDone: begin
                    if (bus.nAS) begin
                        bus.nDTACK <= 1'b1;
                        bus.BUSY   <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StBerr: begin
                    if (bus.MEM_ACK) ack_seen_q <= 1'b1;
                    if (bus.nAS) begin
                        bus.nBERR <= 1'b1;
                        bus.BUSY  <= ~acked;
                        state_q   <= acked ? StIdle : StDrain;
                    end
                end
                StDrain: begin
                    // Wait out the orphaned backend access before accepting a new request.
                    if (bus.MEM_ACK) begin
                        bus.BUSY <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    bus.nDTACK <= 1'b1;
                    bus.nBERR  <= 1'b1;
                    bus.BUSY   <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c1_dtack_sched.sv
// Directed bench for c1_dtack_sched: a vector table of single bus cycles plus hand sequences
// for timeout, abort/drain and reset-mid-cycle.
module tb_c1_dtack_sched;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    c1_dtack_sched_if bus ();

    c1_dtack_sched #(.TIMEOUT(255), .TW(10)) dut (
        .CLK_68KCLK (clk),
        .RESET      (rst),
        .bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] zsel;     // {rom, srom, wram, port, card}, active-high here
        logic       rw;
        logic       nromwait;
        logic       npwait1;
        logic       npwait0;
        int         ack_at;   // edge offset from N where MEM_ACK goes high
        logic [2:0] exp_zone;
        logic       exp_wr;
        int         exp_dt;   // edge offset from N where nDTACK must fall
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_zones(input logic [4:0] zsel);
        bus.nROM_ZONE  = ~zsel[4];
        bus.nSROM_ZONE = ~zsel[3];
        bus.nWRAM_ZONE = ~zsel[2];
        bus.nPORT_ZONE = ~zsel[1];
        bus.nCARD_ZONE = ~zsel[0];
    endtask

    function automatic logic [7:0] outs();
        return {bus.MEM_REQ, bus.MEM_WR, bus.MEM_ZONE, bus.nDTACK, bus.nBERR, bus.BUSY};
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        int dt_off;
        int reqs;
        string tag;
        tag = $sformatf("vec%0d", i);
        set_zones(v.zsel);
        bus.RW       = v.rw;
        bus.nROMWAIT = v.nromwait;
        bus.nPWAIT1  = v.npwait1;
        bus.nPWAIT0  = v.npwait0;
        bus.MEM_ACK  = 1'b0;
        bus.nAS      = 1'b0;
        tick();  // edge N
        chk({tag, " req"}, 32'(bus.MEM_REQ), 32'd1);
        chk({tag, " zone"}, 32'(bus.MEM_ZONE), 32'(v.exp_zone));
        chk({tag, " wr"}, 32'(bus.MEM_WR), 32'(v.exp_wr));
        dt_off = -1;
        reqs   = 1;
        for (int off = 1; off <= 40; off++) begin
            if (off == v.ack_at) bus.MEM_ACK = 1'b1;
            tick();
            if (bus.MEM_REQ) reqs++;
            if (!bus.nDTACK) begin
                dt_off = off;
                break;
            end
        end
        bus.MEM_ACK = 1'b0;
        chk({tag, " dtack edge"}, 32'(dt_off), 32'(v.exp_dt));
        chk({tag, " req count"}, 32'(reqs), 32'd1);
        tick();  // nAS still low: DTACK held
        chk({tag, " dtack hold"}, 32'(bus.nDTACK), 32'd0);
        bus.nAS = 1'b1;
        tick();
        chk({tag, " release"}, 32'({bus.nDTACK, bus.nBERR, bus.BUSY}), 32'b110);
    endtask

    initial begin
        int ber_off;
        int dt_seen;
        int reqs;
        n_checks = 0;
        n_pass   = 0;

        //        zsel      rw  nrw  pw1  pw0 ack zone wr dt
        vecs[0]  = '{5'b10000, 1'b1, 1'b1, 1'b1, 1'b1, 1, 3'd1, 1'b0, 1};
        vecs[1]  = '{5'b10000, 1'b1, 1'b0, 1'b1, 1'b1, 1, 3'd1, 1'b0, 3};
        vecs[2]  = '{5'b00010, 1'b1, 1'b1, 1'b0, 1'b1, 1, 3'd4, 1'b0, 4};
        vecs[3]  = '{5'b00010, 1'b1, 1'b1, 1'b0, 1'b1, 7, 3'd4, 1'b0, 7};
        vecs[4]  = '{5'b00010, 1'b1, 1'b1, 1'b1, 1'b0, 1, 3'd4, 1'b0, 3};
        vecs[5]  = '{5'b00010, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3'd4, 1'b1, 1};
        vecs[6]  = '{5'b00010, 1'b1, 1'b1, 1'b1, 1'b1, 2, 3'd4, 1'b0, 2};
        vecs[7]  = '{5'b00001, 1'b1, 1'b1, 1'b1, 1'b1, 1, 3'd5, 1'b0, 3};
        vecs[8]  = '{5'b00001, 1'b0, 1'b1, 1'b1, 1'b1, 1, 3'd5, 1'b1, 3};
        vecs[9]  = '{5'b01000, 1'b0, 1'b1, 1'b1, 1'b1, 1, 3'd2, 1'b1, 1};
        vecs[10] = '{5'b00100, 1'b1, 1'b0, 1'b0, 1'b1, 4, 3'd3, 1'b0, 4};
        vecs[11] = '{5'b10001, 1'b1, 1'b1, 1'b1, 1'b1, 1, 3'd1, 1'b0, 1};
        vecs[12] = '{5'b01110, 1'b1, 1'b0, 1'b0, 1'b1, 2, 3'd2, 1'b0, 2};
        vecs[13] = '{5'b00001, 1'b1, 1'b0, 1'b1, 1'b1, 5, 3'd5, 1'b0, 5};

        rst = 1'b1;
        bus.nAS = 1'b1;
        bus.RW = 1'b1;
        set_zones(5'b00000);
        bus.nROMWAIT = 1'b1;
        bus.nPWAIT0 = 1'b1;
        bus.nPWAIT1 = 1'b1;
        bus.MEM_ACK = 1'b0;
        tick();
        tick();
        chk("reset outputs", 32'(outs()), 32'b0_0_000_1_1_0);
        rst = 1'b0;

        // nAS with no zone selected: not ours
        bus.nAS = 1'b0;
        tick();
        tick();
        chk("no zone", 32'({bus.MEM_REQ, bus.nDTACK, bus.BUSY}), 32'b010);
        bus.nAS = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // WRAM write, backend never answers: bus error at N+255, then drain
        set_zones(5'b00100);
        bus.RW = 1'b0;
        bus.nAS = 1'b0;
        tick();
        chk("to req", 32'({bus.MEM_REQ, bus.MEM_WR, bus.MEM_ZONE}), 32'b1_1_011);
        ber_off = -1;
        dt_seen = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (!bus.nDTACK) dt_seen++;
            if (!bus.nBERR) begin
                ber_off = k;
                break;
            end
        end
        chk("to berr edge", 32'(ber_off), 32'd255);
        chk("to no dtack", 32'(dt_seen), 32'd0);
        tick();
        tick();
        chk("to berr hold", 32'({bus.nBERR, bus.nDTACK}), 32'b01);
        bus.nAS = 1'b1;
        tick();
        chk("to drain", 32'({bus.nBERR, bus.nDTACK, bus.BUSY}), 32'b111);
        tick();
        tick();
        chk("to drain hold", 32'(bus.BUSY), 32'd1);
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        chk("to idle", 32'(bus.BUSY), 32'd0);
        tick();

        // ROM with waits, nAS released at N+2 before ack: drain blocks next cycle
        set_zones(5'b10000);
        bus.RW = 1'b1;
        bus.nROMWAIT = 1'b0;
        bus.nAS = 1'b0;
        tick();
        chk("ab req", 32'(bus.MEM_REQ), 32'd1);
        tick();
        bus.nAS = 1'b1;
        tick();
        chk("ab drain", 32'({bus.nDTACK, bus.BUSY}), 32'b11);
        bus.nAS = 1'b0;
        reqs = 0;
        dt_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.MEM_REQ) reqs++;
            if (!bus.nDTACK) dt_seen++;
        end
        chk("ab blocked req", 32'(reqs), 32'd0);
        chk("ab blocked dtack", 32'(dt_seen), 32'd0);
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        chk("ab idle entry", 32'({bus.MEM_REQ, bus.BUSY}), 32'b00);
        tick();
        chk("ab new req", 32'({bus.MEM_REQ, bus.MEM_ZONE}), 32'b1_001);
        bus.nAS = 1'b1;
        tick();
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        chk("ab cleanup", 32'(bus.BUSY), 32'd0);

        // reset with MEM_REQ pending, then a late ack
        set_zones(5'b00010);
        bus.nPWAIT1 = 1'b0;
        bus.nPWAIT0 = 1'b1;
        bus.nAS = 1'b0;
        tick();
        chk("rst req", 32'(bus.MEM_REQ), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst mid", 32'(outs()), 32'b0_0_000_1_1_0);
        rst = 1'b0;
        bus.nAS = 1'b1;
        bus.MEM_ACK = 1'b1;
        dt_seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!bus.nDTACK || bus.BUSY || bus.MEM_REQ) dt_seen++;
        end
        bus.MEM_ACK = 1'b0;
        chk("rst late ack", 32'(dt_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/c1_dtack_sched.md
Name: c1_dtack_sched

Overview:
- Per-bus-cycle sequencer for the 68K bus. Replaces free-running wait counting with a scheduler that issues one memory-backend request per 68K cycle to SDRAM/BRAM.
- Asserts nDTACK only when both are true: the zone's programmed wait states have elapsed, and the backend has acknowledged.
- Drives nBERR on backend timeout. Sits between the C1 zone decoder and the memory arbiter.

Parameters:
- TIMEOUT, 255: WAIT-state cycles before bus error. Legal range 4..1023.
- TW, 10: timeout counter width. Must satisfy 2^TW > TIMEOUT.

Ports:
- CLK_68KCLK  in  1  68K clock; all logic on the rising edge.
- RESET  in  1  synchronous reset, active-high.
- nAS  in  1  68K address strobe, active-low.
- RW  in  1  68K read(1)/write(0).
- nROM_ZONE, nSROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nCARD_ZONE  in  1 each  zone selects, active-low.
- nROMWAIT, nPWAIT0, nPWAIT1  in  1 each  cart wait configuration.
- MEM_REQ  out  1  one-cycle request pulse to the backend.
- MEM_WR  out  1  write flag, valid with MEM_REQ.
- MEM_ZONE  out  3  latched zone code.
- MEM_ACK  in  1  backend completion, one-cycle or level.
- nDTACK  out  1  data acknowledge, active-low.
- nBERR  out  1  bus error, active-low.
- BUSY  out  1  high in any state except IDLE.

Behaviour:
- Registered outputs throughout.
- Reset values: MEM_REQ=0, MEM_WR=0, MEM_ZONE=0, nDTACK=1, nBERR=1, BUSY=0, state IDLE, counters 0.
- Reset mid-cycle abandons any pending request; MEM_ACK arriving after reset is ignored.
- Zone code, by priority: ROM=1 > SROM=2 > WRAM=3 > PORT=4 > CARD=5. No zone = 0.
- Wait count W, latched at cycle start:
  - ROM with nROMWAIT=0: W=2.
  - PORT with nPWAIT1/nPWAIT0 = 1/0: W=2.
  - PORT with nPWAIT1/nPWAIT0 = 0/1: W=3.
  - PORT with 0/0 or 1/1: W=0.
  - CARD: W=2.
  - All other zones: W=0.
- States: IDLE, WAIT, DONE, BERR, DRAIN.
- IDLE, at edge N with nAS=0 and zone code ≠ 0:
  - Latch MEM_ZONE and MEM_WR=~RW.
  - MEM_REQ=1 for exactly one cycle (cleared at N+1).
  - Load wait counter with W, clear timeout counter, clear ack_seen. Go to WAIT.
- IDLE with nAS=0 and zone code = 0: stay IDLE. No request; nDTACK stays 1 because another source owns it.
- WAIT:
  - MEM_ACK is sampled from edge N+1 onward; any high sample sets ack_seen (sticky).
  - The wait counter decrements each edge until it reaches 0.
  - At edge E, if counter==0 and (ack_seen or MEM_ACK): nDTACK=0, go to DONE. Net result: nDTACK falls at edge max(N+1+W, A), where A is the first edge ≥ N+1 sampling MEM_ACK=1.
  - If nAS=1 is sampled first (aborted cycle): if acked, go to IDLE; otherwise go to DRAIN.
  - If the timeout counter reaches TIMEOUT at edge N+TIMEOUT with no DTACK: nBERR=0, go to BERR.
  - DTACK wins over timeout on the same edge.
- DONE: hold nDTACK=0 until nAS=1 is sampled. On that edge, nDTACK=1 and go to IDLE. A new cycle can start no earlier than the next edge.
- BERR: hold nBERR=0 until nAS=1 is sampled. Then nBERR=1 and go to IDLE if ack_seen, otherwise DRAIN.
- DRAIN: BUSY=1, nDTACK=1. No new request is accepted while in DRAIN, even if nAS=0. On MEM_ACK, go to IDLE; a new cycle is then detected at the following edge.
- nDTACK and nBERR are never low simultaneously. MEM_REQ is never asserted twice for one nAS assertion.

Test Plan:
- ROM, nROMWAIT=1, MEM_ACK high at N+1: MEM_REQ at N, MEM_ZONE=1, nDTACK low at N+1, high one edge after nAS=1.
- PORT, nPWAIT1=0/nPWAIT0=1, ack at N+1: nDTACK low at N+4 (W=3). Same stimulus with ack at N+7: nDTACK low at N+7.
- WRAM write (RW=0), ack never, TIMEOUT=255: MEM_WR=1, nBERR low at N+255 until nAS high, then DRAIN. Ack at +3 → IDLE, BUSY=0.
- nAS rises at N+2 before ack on a ROM cycle with nROMWAIT=0: no DTACK; DRAIN blocks a new nAS=0 until MEM_ACK, then MEM_REQ at the edge after IDLE entry.
- RESET asserted during WAIT with MEM_REQ pending: next edge all outputs at reset values; a late MEM_ACK produces no nDTACK.
- Back-to-back CARD cycles with ack at N+1: nDTACK low at N+3 each cycle, exactly one MEM_REQ per nAS assertion, MEM_ZONE=5.
